// File: rtl/clock_edit_fsm.sv
// Clock/calendar edit-mode controller: walks the edit field on btn_mode,
// issues field increments on btn_inc, drives blanking and auto-exits on idle.
module clock_edit_fsm #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       event_clk1s,
  input  logic       blink,
  output logic       run_en,
  output logic       blink_en,
  output logic [2:0] field_sel,
  output logic [6:0] blank_mask,
  output logic [6:0] inc_pulse
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    E_SEC  = 3'd1,
    E_MIN  = 3'd2,
    E_HOUR = 3'd3,
    E_DAY  = 3'd4,
    E_MON  = 3'd5,
    E_YEAR = 3'd6,
    E_CENT = 3'd7
  } state_e;

  localparam logic [5:0] IdleLast = 6'(TIMEOUT_S - 1);

  state_e     state_q, state_d;
  logic [5:0] idle_q, idle_d;
  logic [6:0] blank_q, blank_d;
  logic [6:0] inc_q, inc_d;
  logic       edit;

  assign edit = (state_q != RUN);

  // State, idle counter and registered pulse/blank outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      idle_q  <= 6'd0;
      blank_q <= 7'd0;
      inc_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      blank_q <= blank_d;
      inc_q   <= inc_d;
    end
  end

  // Next state: mode beats inc, any button beats the idle timeout
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (btn_mode) begin
      state_d = state_e'(state_q + 3'd1);
    end else if (!btn_inc && event_clk1s
                 && edit && idle_q == IdleLast) begin
      state_d = RUN;
    end
    if (btn_mode || btn_inc || !edit
        || state_d != state_q) begin
      idle_d = 6'd0;
    end else if (event_clk1s) begin
      idle_d = idle_q + 6'd1;
    end
  end

  // Outputs: levels decoded from the state register, pulses pre-registered
  always_comb begin
    run_en    = !edit;
    blink_en  = edit;
    field_sel = state_q;
    inc_d     = 7'd0;
    blank_d   = 7'd0;
    if (edit && btn_inc && !btn_mode) begin
      inc_d = 7'd1 << (state_q - 3'd1);
    end
    if (state_d != RUN && blink) begin
      blank_d = 7'd1 << (state_d - 3'd1);
    end
  end

  assign blank_mask = blank_q;
  assign inc_pulse  = inc_q;

endmodule
